// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module      : player_motion
// Description : Per-frame player position generator (walk, jump, gravity),
//               clamped to the playfield. Optional macro VARIABLE_JUMP_EN
//               enables short hops when the jump key is released early.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion #(
    parameter int X_START   = 320,
    parameter int Y_GROUND  = 399,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int SIZE      = 8,
    parameter int WALK_STEP = 2,
    parameter int JUMP_VEL  = 12,
    parameter int MAX_FALL  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [9:0] Size,
    output logic       airborne,
    output logic       facing_left
);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } state_t;

    localparam logic [7:0]         c_key_left  = 8'h04;
    localparam logic [7:0]         c_key_right = 8'h07;
    localparam logic [7:0]         c_key_jump  = 8'h1A;
    localparam logic signed [10:0] c_x_lo      = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] c_x_hi      = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] c_y_top     = 11'(SIZE);
    localparam logic signed [10:0] c_y_gnd     = 11'(Y_GROUND);
    localparam logic signed [10:0] c_walk      = 11'(WALK_STEP);
    localparam logic signed [10:0] c_jump_vel  = 11'(-JUMP_VEL);
    localparam logic signed [10:0] c_max_fall  = 11'(MAX_FALL);
`ifdef VARIABLE_JUMP_EN
    localparam logic signed [10:0] c_short_vel = -11'sd2;
`endif

    state_t             r_state;
    logic               r_frame_d;
    logic               r_jump_armed;
    logic               r_airborne;
    logic               r_facing_left;
    logic [9:0]         r_pos_x;
    logic [9:0]         r_pos_y;
    logic signed [10:0] r_vel_y;

    logic               w_tick;
    logic               w_left;
    logic               w_right;
    logic               w_jump;
    logic signed [10:0] w_x_ext;
    logic signed [10:0] w_x_cand;
    logic signed [10:0] w_vel_eff;
    logic signed [10:0] w_y_cand;
    logic signed [10:0] w_vel_inc;
    logic signed [10:0] w_vel_next;
    logic               w_unused;

    assign w_tick  = frame_clk & ~r_frame_d;
    assign w_left  = (keycode0 == c_key_left)  || (keycode1 == c_key_left);
    assign w_right = (keycode0 == c_key_right) || (keycode1 == c_key_right);
    assign w_jump  = (keycode0 == c_key_jump)  || (keycode1 == c_key_jump);

    // Candidates are widened to 11-bit signed so clamping sees true under/overflow.
    always_comb begin
        w_x_ext  = $signed({1'b0, r_pos_x});
        w_x_cand = w_x_ext;
        if (w_left && !w_right) begin
            w_x_cand = w_x_ext - c_walk;
            if (w_x_cand < c_x_lo) w_x_cand = c_x_lo;
        end else if (w_right && !w_left) begin
            w_x_cand = w_x_ext + c_walk;
            if (w_x_cand > c_x_hi) w_x_cand = c_x_hi;
        end

        w_vel_eff = r_vel_y;
`ifdef VARIABLE_JUMP_EN
        if (r_state == RISING && !w_jump && r_vel_y < c_short_vel) w_vel_eff = c_short_vel;
`endif
        w_y_cand   = $signed({1'b0, r_pos_y}) + w_vel_eff;
        w_vel_inc  = w_vel_eff + 11'sd1;
        w_vel_next = (w_vel_inc > c_max_fall) ? c_max_fall : w_vel_inc;
    end

    assign w_unused = ^{w_x_cand[10], w_y_cand[10]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_d     <= 1'b0;
            r_state       <= GROUNDED;
            r_jump_armed  <= 1'b1;
            r_airborne    <= 1'b0;
            r_facing_left <= 1'b0;
            r_pos_x       <= 10'(X_START);
            r_pos_y       <= 10'(Y_GROUND);
            r_vel_y       <= 11'sd0;
        end else begin
            r_frame_d <= frame_clk;
            if (w_tick) begin
                r_pos_x <= w_x_cand[9:0];
                if (w_left && !w_right)      r_facing_left <= 1'b1;
                else if (w_right && !w_left) r_facing_left <= 1'b0;

                case (r_state)
                    GROUNDED: begin
                        if (w_jump && r_jump_armed) begin
                            r_vel_y      <= c_jump_vel;
                            r_state      <= RISING;
                            r_airborne   <= 1'b1;
                            r_jump_armed <= 1'b0;
                        end else begin
                            r_vel_y <= 11'sd0;
                            r_pos_y <= c_y_gnd[9:0];
                            if (!w_jump) r_jump_armed <= 1'b1;
                        end
                    end
                    default: begin
                        if (w_y_cand < c_y_top) begin
                            r_pos_y <= c_y_top[9:0];
                            r_vel_y <= 11'sd0;
                            r_state <= FALLING;
                        end else if (w_y_cand >= c_y_gnd) begin
                            r_pos_y    <= c_y_gnd[9:0];
                            r_vel_y    <= 11'sd0;
                            r_state    <= GROUNDED;
                            r_airborne <= 1'b0;
                        end else begin
                            r_pos_y <= w_y_cand[9:0];
                            r_vel_y <= w_vel_next;
                            r_state <= (w_vel_next < 11'sd0) ? RISING : FALLING;
                        end
                    end
                endcase
            end
        end
    end

    assign PosX        = r_pos_x;
    assign PosY        = r_pos_y;
    assign Size        = 10'(SIZE);
    assign airborne    = r_airborne;
    assign facing_left = r_facing_left;

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion
// Description : Self-checking bench for player_motion against a frame-level
//               behavioural model; VARIABLE_JUMP_EN selects the short-hop case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode0 = 8'h00;
    logic [7:0] keycode1 = 8'h00;
    logic [9:0] PosX, PosY, Size;
    logic       airborne, facing_left;

    int checks = 0;
    int failures = 0;

    // Behavioural model: plain integers, one call per frame.
    int mx, my, mv;
    bit mair, mface, marmed;

    player_motion dut (
        .Clk        (clk),
        .Reset      (rst),
        .frame_clk  (frame_clk),
        .keycode0   (keycode0),
        .keycode1   (keycode1),
        .PosX       (PosX),
        .PosY       (PosY),
        .Size       (Size),
        .airborne   (airborne),
        .facing_left(facing_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 399; mv = 0;
        mair = 0; mface = 0; marmed = 1;
    endtask

    task automatic model_step();
        bit l, r, j;
        int v, c, nv;
        l = (keycode0 == 8'h04) || (keycode1 == 8'h04);
        r = (keycode0 == 8'h07) || (keycode1 == 8'h07);
        j = (keycode0 == 8'h1A) || (keycode1 == 8'h1A);
        if (l && !r) begin
            mx = (mx - 2 < 8) ? 8 : mx - 2;
            mface = 1;
        end else if (r && !l) begin
            mx = (mx + 2 > 631) ? 631 : mx + 2;
            mface = 0;
        end
        if (!mair) begin
            if (j && marmed) begin
                mv = -12; mair = 1; marmed = 0;
            end else begin
                my = 399; mv = 0;
                if (!j) marmed = 1;
            end
        end else begin
            v = mv;
`ifdef VARIABLE_JUMP_EN
            if (!j && v < -2) v = -2;
`endif
            c  = my + v;
            nv = (v + 1 > 8) ? 8 : v + 1;
            if (c < 8) begin
                my = 8; mv = 0;
            end else if (c >= 399) begin
                my = 399; mv = 0; mair = 0;
            end else begin
                my = c; mv = nv;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PosX"}, int'(PosX), mx);
        check({tag, ".PosY"}, int'(PosY), my);
        check({tag, ".airborne"}, int'(airborne), int'(mair));
        check({tag, ".facing"}, int'(facing_left), int'(mface));
    endtask

    // One frame strobe: high for hi cycles, low for lo cycles, then compare.
    task automatic frame(input int hi, input int lo, input string tag);
        @(negedge clk);
        frame_clk = 1'b1;
        model_step();
        repeat (hi) @(negedge clk);
        frame_clk = 1'b0;
        repeat (lo) @(negedge clk);
        check_all(tag);
    endtask

    task automatic keys(input logic [7:0] k0, input logic [7:0] k1);
        keycode0 = k0;
        keycode1 = k1;
    endtask

    initial begin
        int takeoffs;
        bit prev_air;

        // Reset and idle frames
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("reset");
        check("reset.Size", int'(Size), 8);
        repeat (3) frame(1, 1, "idle");
        check("idle.PosX", int'(PosX), 320);
        check("idle.PosY", int'(PosY), 399);

        // Walking right, then both keys hold position
        keys(8'h07, 8'h00);
        repeat (10) frame(1, 1, "walk_r");
        check("walk_r.PosX", int'(PosX), 340);
        keys(8'h04, 8'h07);
        repeat (5) frame(1, 1, "both");
        check("both.PosX", int'(PosX), 340);

        // Right clamp then left clamp
        keys(8'h07, 8'h00);
        repeat (145) frame(1, 1, "to630");
        check("to630.PosX", int'(PosX), 630);
        repeat (3) frame(1, 1, "clamp_r");
        check("clamp_r.PosX", int'(PosX), 631);
        keys(8'h00, 8'h04);
        repeat (320) frame(1, 1, "walk_l");
        check("clamp_l.PosX", int'(PosX), 8);
        check("clamp_l.facing", int'(facing_left), 1);

        // Jump tap: one frame of W, then released
        keys(8'h00, 8'h00);
        frame(1, 1, "pre_jump");
        keys(8'h1A, 8'h00);
        frame(1, 1, "jump");
        check("jump.airborne", int'(airborne), 1);
        check("jump.PosY", int'(PosY), 399);
        keys(8'h00, 8'h00);
        for (int i = 1; i <= 30; i++) begin
            frame(1, 1, "air");
`ifndef VARIABLE_JUMP_EN
            if (i == 12) check("peak.PosY", int'(PosY), 321);
            if (i == 26) check("air26.airborne", int'(airborne), 1);
            if (i == 27) begin
                check("land.PosY", int'(PosY), 399);
                check("land.airborne", int'(airborne), 0);
            end
`endif
        end

        // Holding W yields one jump only
        keys(8'h1A, 8'h00);
        takeoffs = 0;
        prev_air = 1'b0;
        for (int i = 0; i < 60; i++) begin
            frame(1, 1, "hold_w");
            if (airborne && !prev_air) takeoffs++;
            prev_air = airborne;
        end
        check("hold_w.takeoffs", takeoffs, 1);

        // A long frame_clk pulse is a single update
        keys(8'h07, 8'h00);
        frame(50, 2, "long_pulse");
        check("long_pulse.PosX", int'(PosX), 10);

        // Reset asserted mid-jump, coincident with a frame rise
        keys(8'h00, 8'h00);
        frame(1, 1, "pre_jump2");
        keys(8'h1A, 8'h00);
        frame(1, 1, "jump2");
        keys(8'h00, 8'h00);
        repeat (4) frame(1, 1, "air2");
        @(negedge clk);
        rst = 1'b1;
        frame_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_clk = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("rst_mid");
        check("rst_mid.PosY", int'(PosY), 399);
        check("rst_mid.airborne", int'(airborne), 0);
        repeat (2) frame(1, 1, "post_rst");
        check("post_rst.PosY", int'(PosY), 399);

`ifdef VARIABLE_JUMP_EN
        // Short hop: W held for the jump tick plus two air ticks
        frame(1, 1, "pre_hop");
        keys(8'h1A, 8'h00);
        repeat (3) frame(1, 1, "hop_hold");
        check("hop.PosY2", int'(PosY), 376);
        keys(8'h00, 8'h00);
        frame(1, 1, "hop_rel");
        check("hop.PosY3", int'(PosY), 374);
        frame(1, 1, "hop_peak");
        check("hop.peak", int'(PosY), 373);
        repeat (30) frame(1, 1, "hop_fall");
        check("hop.land", int'(PosY), 399);
`endif

        // Randomized frames against the model
        for (int i = 0; i < 300; i++) begin
            logic [7:0] k[2];
            for (int n = 0; n < 2; n++) begin
                case ($urandom_range(0, 4))
                    0:       k[n] = 8'h00;
                    1:       k[n] = 8'h04;
                    2:       k[n] = 8'h07;
                    3:       k[n] = 8'h1A;
                    default: k[n] = 8'($urandom);
                endcase
            end
            keys(k[0], k[1]);
            frame($urandom_range(1, 4), $urandom_range(1, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
